bus_arbit_rr: RTL

N-master bus arbiter; the parametrised successor of the two-master arbiter. It selects one bus owner per cycle from NUM_M request lines using a runtime-selectable fixed-priority or round-robin policy. Grants are registered and exactly one-hot at all times; with no requests, the grant parks on a default master. It sits between the masters' request logic and the bus address/data mux, which is steered by grant_idx.

---
 rtl/bus_arbit_rr.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bus_arbit_rr.sv
// N-master bus arbiter: registered one-hot grant, fixed-priority or round-robin policy, parks on PARK_ID when idle.
// Optional tenure limit enabled by defining ARB_HOLD_LIMIT_EN (MAX_HOLD cycles before a waiting master is served).
module bus_arbit_rr #(
    parameter int NUM_M    = 4,
    parameter int PARK_ID  = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_M-1:0]         req,
    input  logic                     arb_mode,
    output logic [NUM_M-1:0]         grant,
    output logic [$clog2(NUM_M)-1:0] grant_idx,
    output logic                     bus_busy,
    output logic                     grant_chg
);

    localparam int IDX_W = $clog2(NUM_M);
    localparam logic [NUM_M-1:0] ONE_HOT0 = {{(NUM_M-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        PARKED = 1'b0,
        OWNED  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_M-1:0]   r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_chg;
    logic [NUM_M-1:0]   w_cand;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [NUM_M-1:0]   w_grant_nxt;
    logic               w_hold_expired;

    if (NUM_M < 2 || NUM_M > 16) begin : g_bad_num_m
        $error("bus_arbit_rr: NUM_M must be in 2..16");
    end
    if (PARK_ID < 0 || PARK_ID >= NUM_M) begin : g_bad_park_id
        $error("bus_arbit_rr: PARK_ID must be below NUM_M");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("bus_arbit_rr: MAX_HOLD must be at least 1");
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int TEN_W = $clog2(MAX_HOLD + 1);
    logic [TEN_W-1:0] r_tenure;

    // Tenure expires only when some other master is actually waiting.
    always_comb begin
        w_hold_expired = (r_tenure == TEN_W'(MAX_HOLD - 1)) && (|(req & ~r_grant));
    end

    // Tenure counter: counts kept edges, clears on owner change, saturates at MAX_HOLD-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tenure <= {TEN_W{1'b0}};
        end else if (w_idx_nxt != r_grant_idx) begin
            r_tenure <= {TEN_W{1'b0}};
        end else if (r_tenure != TEN_W'(MAX_HOLD - 1)) begin
            r_tenure <= r_tenure + TEN_W'(1);
        end else begin
            r_tenure <= r_tenure;
        end
    end
`else
    assign w_hold_expired = 1'b0;
`endif

    // Next-owner selection; the round-robin pointer is the current grant_idx.
    always_comb begin
        w_idx_nxt = IDX_W'(PARK_ID);
        if (w_hold_expired) begin
            w_cand = req & ~r_grant;
        end else begin
            w_cand = req;
        end
        if (req[r_grant_idx] && !w_hold_expired) begin
            w_idx_nxt = r_grant_idx;
        end else if (|w_cand) begin
            if (arb_mode || w_hold_expired) begin
                // Descending so the nearest slot after the owner is assigned last.
                for (int k = NUM_M; k >= 1; k--) begin
                    if (w_cand[(int'(r_grant_idx) + k) % NUM_M]) begin
                        w_idx_nxt = IDX_W'((int'(r_grant_idx) + k) % NUM_M);
                    end else begin
                        w_idx_nxt = w_idx_nxt;
                    end
                end
            end else begin
                for (int i = NUM_M - 1; i >= 0; i--) begin
                    if (w_cand[i]) begin
                        w_idx_nxt = IDX_W'(i);
                    end else begin
                        w_idx_nxt = w_idx_nxt;
                    end
                end
            end
        end else begin
            w_idx_nxt = IDX_W'(PARK_ID);
        end
        w_grant_nxt = ONE_HOT0 << w_idx_nxt;
        w_state_nxt = (|(req & w_grant_nxt)) ? OWNED : PARKED;
    end

    // PARKED/OWNED state register; it drives bus_busy directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PARKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant registers and owner-change pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= ONE_HOT0 << PARK_ID;
            r_grant_idx <= IDX_W'(PARK_ID);
            r_grant_chg <= 1'b0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_idx_nxt;
            r_grant_chg <= (w_idx_nxt != r_grant_idx);
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign bus_busy  = (r_state == OWNED);
    assign grant_chg = r_grant_chg;

endmodule
